// File: rtl/shift_4094_pkg.sv
// Shared types for the CD4094 daisy-chain controller: the frame FSM state
// encoding and a helper that gives the length of one complete frame in clk cycles.
package shift_4094_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BIT_LO,
        BIT_HI,
        STROBE_HI,
        STROBE_LO
    } state_t;

    // One LOAD cycle, then two half periods per bit, then two strobe half periods.
    function automatic int frameCycles(input int chainLen, input int clkDiv);
        return 1 + (16 * chainLen + 2) * clkDiv;
    endfunction

endpackage

// File: rtl/shift_4094_prescaler.sv
// Half-bit-period timebase for the 4094 chain controller. It counts
// 0..CLK_DIV-1 and raises o_half_tick on the terminal count. i_clear
// restarts the count, so a frame always begins on a fresh half period.
module shift_4094_prescaler
    import shift_4094_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_half_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] r_count;

    // Free-running modulo-CLK_DIV counter with a synchronous restart
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_count <= '0;
        end else if (r_count == CNT_W'(CLK_DIV - 1)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_half_tick = (r_count == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/shift_4094_chain_ctrl.sv
// Scheduler for a daisy chain of CHAIN_LEN CD4094 shift registers used as
// write-only outputs. Host writes land in a shadow byte per IC and mark the
// chain dirty; while dirty, the whole chain is streamed as one frame (IC
// CHAIN_LEN-1 first, MSB first) and latched with a single strobe.
// Optional feature: define SHIFT_4094_AUTO_REFRESH_EN to repaint the chain
// after REFRESH_CYCLES idle cycles.
module shift_4094_chain_ctrl
    import shift_4094_pkg::*;
#(
    parameter int CHAIN_LEN      = 2,
    parameter int IDX_W          = 1,
    parameter int CLK_DIV        = 4,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [7:0]       i_wr_data,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_data_out,
    output logic             o_register_clock,
    output logic             o_strobe
);

    localparam int FRAME_BITS = 8 * CHAIN_LEN;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    logic [FRAME_BITS-1:0] r_shadow;
    logic [FRAME_BITS-1:0] r_frame;
    logic                  r_dirty;
    state_t                r_state;
    logic [BIT_W-1:0]      r_bitCnt;

    logic w_halfTick;
    logic w_wrAccept;
    logic w_load;
    logic w_refreshHit;

    assign w_load = (r_state == LOAD);

    shift_4094_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_load),
        .o_half_tick (w_halfTick)
    );

    // A write only counts when its index names a real IC in the chain
    always_comb begin
        w_wrAccept = 1'b0;
        for (int k = 0; k < CHAIN_LEN; k++) begin
            if (i_wr_en && (i_wr_idx == IDX_W'(k))) begin
                w_wrAccept = 1'b1;
            end
        end
    end

    // Shadow bytes, IC k occupying bits [8k+7:8k]
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shadow <= '0;
        end else begin
            for (int k = 0; k < CHAIN_LEN; k++) begin
                if (i_wr_en && (i_wr_idx == IDX_W'(k))) begin
                    r_shadow[k*8 +: 8] <= i_wr_data;
                end
            end
        end
    end

`ifdef SHIFT_4094_AUTO_REFRESH_EN
    localparam int REF_W = $clog2(REFRESH_CYCLES + 1);

    logic [REF_W-1:0] r_refreshCnt;

    assign w_refreshHit = (r_state == IDLE) && !r_dirty &&
                          (r_refreshCnt == REF_W'(REFRESH_CYCLES - 1));

    // Counts quiet idle cycles; any frame activity restarts the count
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || (r_state != IDLE) || w_refreshHit) begin
            r_refreshCnt <= '0;
        end else if (!r_dirty) begin
            r_refreshCnt <= r_refreshCnt + 1'b1;
        end
    end
`else
    logic w_unusedRefresh;

    assign w_refreshHit    = 1'b0;
    assign w_unusedRefresh = (REFRESH_CYCLES == 0);
`endif

    // Dirty flag: starts set so reset paints zeros; a new request beats the LOAD clear
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dirty <= 1'b1;
        end else if (w_wrAccept || i_flush || w_refreshHit) begin
            r_dirty <= 1'b1;
        end else if (w_load) begin
            r_dirty <= 1'b0;
        end
    end

    // Frame FSM; every pin is a register so the board sees clean edges
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state          <= IDLE;
            r_frame          <= '0;
            r_bitCnt         <= '0;
            o_busy           <= 1'b0;
            o_frame_done     <= 1'b0;
            o_data_out       <= 1'b0;
            o_register_clock <= 1'b0;
            o_strobe         <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_dirty) begin
                        o_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_frame    <= r_shadow;
                    r_bitCnt   <= BIT_W'(FRAME_BITS - 1);
                    o_data_out <= r_shadow[FRAME_BITS-1];
                    r_state    <= BIT_LO;
                end
                BIT_LO: begin
                    if (w_halfTick) begin
                        o_register_clock <= 1'b1;
                        r_state          <= BIT_HI;
                    end
                end
                BIT_HI: begin
                    if (w_halfTick) begin
                        o_register_clock <= 1'b0;
                        if (r_bitCnt != '0) begin
                            r_bitCnt   <= r_bitCnt - 1'b1;
                            o_data_out <= r_frame[r_bitCnt - 1'b1];
                            r_state    <= BIT_LO;
                        end else begin
                            o_strobe <= 1'b1;
                            r_state  <= STROBE_HI;
                        end
                    end
                end
                STROBE_HI: begin
                    if (w_halfTick) begin
                        o_strobe <= 1'b0;
                        r_state  <= STROBE_LO;
                    end
                end
                STROBE_LO: begin
                    if (w_halfTick) begin
                        o_busy       <= 1'b0;
                        o_frame_done <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_4094_chain_ctrl.sv
// Directed testbench for shift_4094_chain_ctrl with CHAIN_LEN=2, CLK_DIV=2.
// A negedge monitor reconstructs what the 4094 chain would sample; the main
// sequence drives directed steps and compares against hand-computed values.
// Optional build: SHIFT_4094_AUTO_REFRESH_EN selects the refresh expectation.
module tb_shift_4094_chain_ctrl;

    localparam int CHAIN_LEN      = 2;
    localparam int IDX_W          = 2;
    localparam int CLK_DIV        = 2;
    localparam int REFRESH_CYCLES = 100;
    localparam int FRAME_CYCLES   = 69;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       wr_en   = 1'b0;
    logic [1:0] wr_idx  = 2'd0;
    logic [7:0] wr_data = 8'd0;
    logic       flush   = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       data_out;
    logic       register_clock;
    logic       strobe;

    shift_4094_chain_ctrl #(
        .CHAIN_LEN      (CHAIN_LEN),
        .IDX_W          (IDX_W),
        .CLK_DIV        (CLK_DIV),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_wr_en          (wr_en),
        .i_wr_idx         (wr_idx),
        .i_wr_data        (wr_data),
        .i_flush          (flush),
        .o_busy           (busy),
        .o_frame_done     (frame_done),
        .o_data_out       (data_out),
        .o_register_clock (register_clock),
        .o_strobe         (strobe)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    logic [63:0] bitLog       = '0;
    int          bitCount     = 0;
    int          strobeCount  = 0;
    int          strobeHigh   = 0;
    int          doneCount    = 0;
    int          busyCycles   = 0;
    int          bitsAtStrobe = 0;
    int          violations   = 0;
    logic        prevRclk     = 1'b0;
    logic        prevStrobe   = 1'b0;
    logic        prevBusy     = 1'b0;
    logic        prevData     = 1'b0;
    logic        armed        = 1'b0;

    int bBits, bStrobe, bStrobeHigh, bDone, bBusy;

    // Observe the pins the way the 4094 chain would: capture data on each clock rise
    always @(negedge clk) begin
        if (register_clock && !prevRclk) begin
            bitLog = {bitLog[62:0], data_out};
            bitCount++;
        end
        if (strobe && !prevStrobe) begin
            strobeCount++;
            bitsAtStrobe = bitCount;
        end
        if (strobe)     strobeHigh++;
        if (frame_done) doneCount++;
        if (busy)       busyCycles++;
        if (armed && rst_n) begin
            if (prevRclk && register_clock && (data_out !== prevData)) violations++;
            if (!prevBusy && !busy && (data_out !== prevData))         violations++;
        end
        prevRclk   = register_clock;
        prevStrobe = strobe;
        prevBusy   = busy;
        prevData   = data_out;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] idx,
                                 input logic [7:0] data, input logic fl);
        wr_en   = we;
        wr_idx  = idx;
        wr_data = data;
        flush   = fl;
        @(negedge clk);
        wr_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic markBase();
        bBits       = bitCount;
        bStrobe     = strobeCount;
        bStrobeHigh = strobeHigh;
        bDone       = doneCount;
        bBusy       = busyCycles;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic waitFrameDone(input string tag, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (frame_done) found = 1'b1;
        end
        checkOutput({tag, " frame_done seen"}, 64'(found), 64'd1);
    endtask

    task automatic checkFrames(input string tag, input int frames,
                               input logic [63:0] expStream);
        logic [63:0] mask;
        mask = (64'd1 << (16 * frames)) - 64'd1;
        checkOutput({tag, " frames"},       64'(doneCount - bDone),         64'(frames));
        checkOutput({tag, " bits"},         64'(bitCount - bBits),          64'(16 * frames));
        checkOutput({tag, " strobes"},      64'(strobeCount - bStrobe),     64'(frames));
        checkOutput({tag, " strobe width"}, 64'(strobeHigh - bStrobeHigh),  64'(2 * frames));
        checkOutput({tag, " busy cycles"},  64'(busyCycles - bBusy),        64'(FRAME_CYCLES * frames));
        checkOutput({tag, " stream"},       bitLog & mask,                  expStream);
    endtask

    initial begin
        $display("[TB] start");

        rst_n = 1'b0;
        settle(3);
        checkOutput("reset outputs",
                    64'({busy, frame_done, data_out, register_clock, strobe}), 64'd0);

        markBase();
        armed = 1'b1;
        rst_n = 1'b1;
        waitFrameDone("t1", 200);
        settle(20);
        checkFrames("t1 zero frame", 1, 64'h0);
        checkOutput("t1 strobe after 16th rise", 64'(bitsAtStrobe - bBits), 64'd16);
        checkOutput("t1 idle after frame", 64'(busy), 64'd0);

        markBase();
        applyStimulus(1'b1, 2'd1, 8'hA5, 1'b0);
        applyStimulus(1'b1, 2'd0, 8'h3C, 1'b0);
        waitFrameDone("t2", 200);
        settle(20);
        checkFrames("t2 A5 3C", 1, 64'hA53C);
        checkOutput("t2 strobe after 16th rise", 64'(bitsAtStrobe - bBits), 64'd16);
        checkOutput("t2 data_out holds last bit", 64'(data_out), 64'd0);

        markBase();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        repeat (20) @(negedge clk);
        checkOutput("t3 busy mid frame", 64'(busy), 64'd1);
        applyStimulus(1'b1, 2'd0, 8'h01, 1'b0);
        waitFrameDone("t3 first", 200);
        waitFrameDone("t3 second", 200);
        settle(20);
        checkFrames("t3 mid-frame write", 2, 64'hA53C_A501);
        checkOutput("t3 data_out holds last bit", 64'(data_out), 64'd1);

        markBase();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
        checkOutput("t4 reached LOAD", 64'({busy, register_clock}), 64'b10);
        applyStimulus(1'b1, 2'd1, 8'hFF, 1'b0);
        waitFrameDone("t4 first", 200);
        waitFrameDone("t4 second", 200);
        settle(20);
        checkFrames("t4 write in LOAD", 2, 64'hA501_FF01);

        markBase();
        applyStimulus(1'b1, 2'd2, 8'h55, 1'b0);
        applyStimulus(1'b1, 2'd3, 8'h66, 1'b0);
        settle(50);
        checkOutput("t5 out-of-range no frame", 64'(doneCount - bDone), 64'd0);
        checkOutput("t5 out-of-range never busy", 64'(busyCycles - bBusy), 64'd0);
        markBase();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        waitFrameDone("t5 flush", 200);
        settle(20);
        checkFrames("t5 flush", 1, 64'hFF01);

        markBase();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        for (int i = 0; i < 200 && (bitCount - bBits) < 5; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("t6 reached bit 5", 64'(bitCount - bBits), 64'd5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t6 pins cleared",
                    64'({busy, frame_done, data_out, register_clock, strobe}), 64'd0);
        settle(4);
        checkOutput("t6 no strobe on partial", 64'(strobeCount - bStrobe), 64'd0);
        checkOutput("t6 no frame_done on partial", 64'(doneCount - bDone), 64'd0);
        markBase();
        rst_n = 1'b1;
        waitFrameDone("t6 after reset", 200);
        settle(20);
        checkFrames("t6 zero frame after reset", 1, 64'h0);

        markBase();
`ifdef SHIFT_4094_AUTO_REFRESH_EN
        waitFrameDone("refresh", 150);
        settle(5);
        checkOutput("refresh frame count", 64'(doneCount - bDone), 64'd1);
`else
        settle(150);
        checkOutput("no frame without request", 64'(doneCount - bDone), 64'd0);
`endif

        checkOutput("data_out stability", 64'(violations), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
